// File: rtl/lvt_arb_pkg.sv
// Shared types and helpers for the lvt_bram port arbiter.
// Request fields are held at fixed maximum widths (16-bit address and data).
package lvt_arb_pkg;

    localparam int LVT_ARB_MAX_REQ  = 8;
    localparam int LVT_ARB_ADDR_MAX = 16;
    localparam int LVT_ARB_DATA_MAX = 16;

    typedef struct packed {
        logic                        we;
        logic [LVT_ARB_ADDR_MAX-1:0] addr;
        logic [LVT_ARB_DATA_MAX-1:0] wdata;
    } lvt_req_t;

    function automatic int lvt_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lvt_wrap_inc(input int i, input int n);
        return (i >= n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/lvt_rr_picker.sv
// Round-robin picker: first set mask bit at or after ptr, wrapping.
// Returns the one-hot grant, its index and whether any bit was found.
module lvt_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && mask[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/lvt_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto the two write ports and one read port of an lvt_bram.
// Optional LVT_ARB_STATS_EN adds saturating write/read/stall counters.
module lvt_port_arbiter
    import lvt_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 7,
    parameter  int DATA_W  = 5,
    parameter  int RD_LAT  = 1,
    localparam int ID_W    = lvt_id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      wr0_en,
    output logic [ADDR_W-1:0]         wr0_addr,
    output logic [DATA_W-1:0]         wr0_data,
    output logic                      wr1_en,
    output logic [ADDR_W-1:0]         wr1_addr,
    output logic [DATA_W-1:0]         wr1_data,
    output logic                      rd0_en,
    output logic [ADDR_W-1:0]         rd0_addr,
`ifdef LVT_ARB_STATS_EN
    output logic [15:0]               stat_wr_cnt,
    output logic [15:0]               stat_rd_cnt,
    output logic [15:0]               stat_stall_cnt,
`endif
    input  logic [DATA_W-1:0]         rd0_data
);

    lvt_req_t req [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]       = '0;
            req[i].we    = req_we[i];
            req[i].addr  = LVT_ARB_ADDR_MAX'(req_addr[i*ADDR_W +: ADDR_W]);
            req[i].wdata = LVT_ARB_DATA_MAX'(req_wdata[i*DATA_W +: DATA_W]);
        end
    end

    logic [NUM_REQ-1:0] wr_mask, rd_mask;
    logic [ID_W-1:0]    wr_ptr, rd_ptr;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_mask[i] = req_valid[i] & req[i].we;
            rd_mask[i] = req_valid[i] & ~req[i].we;
        end
    end

    logic [NUM_REQ-1:0] w0_gnt, w1_gnt, r_gnt;
    logic [ID_W-1:0]    w0_idx, w1_idx, r_idx, w0_nxt;
    logic               w0_found, w1_found, r_found;

    assign w0_nxt = ID_W'(lvt_wrap_inc(int'(w0_idx), NUM_REQ));

    lvt_rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_pick_w0 (
        .mask (wr_mask),
        .ptr  (wr_ptr),
        .grant(w0_gnt),
        .idx  (w0_idx),
        .found(w0_found)
    );

    lvt_rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_pick_w1 (
        .mask (wr_mask & ~w0_gnt),
        .ptr  (w0_nxt),
        .grant(w1_gnt),
        .idx  (w1_idx),
        .found(w1_found)
    );

    lvt_rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_pick_r (
        .mask (rd_mask),
        .ptr  (rd_ptr),
        .grant(r_gnt),
        .idx  (r_idx),
        .found(r_found)
    );

    logic w1_ok, r_ok;

    // No two same-cycle writes to one address, and no read racing a write.
    always_comb begin
        w1_ok = w1_found && (req[w1_idx].addr != req[w0_idx].addr);
        r_ok  = r_found
             && !(w0_found && req[r_idx].addr == req[w0_idx].addr)
             && !(w1_ok && req[r_idx].addr == req[w1_idx].addr);
    end

    assign req_ready = rst ? (w0_gnt
                              | (w1_ok ? w1_gnt : '0)
                              | (r_ok ? r_gnt : '0))
                           : '0;

    logic [ID_W-1:0]   rd_id_q;
    logic [RD_LAT-1:0] vp;
    logic [ID_W-1:0]   ip [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr0_en   <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
            wr1_en   <= 1'b0;
            wr1_addr <= '0;
            wr1_data <= '0;
            rd0_en   <= 1'b0;
            rd0_addr <= '0;
            rd_id_q  <= '0;
            vp       <= '0;
            for (int k = 0; k < RD_LAT; k++) ip[k] <= '0;
        end else begin
            wr0_en <= w0_found;
            if (w0_found) begin
                wr0_addr <= req[w0_idx].addr[ADDR_W-1:0];
                wr0_data <= req[w0_idx].wdata[DATA_W-1:0];
            end
            wr1_en <= w1_ok;
            if (w1_ok) begin
                wr1_addr <= req[w1_idx].addr[ADDR_W-1:0];
                wr1_data <= req[w1_idx].wdata[DATA_W-1:0];
            end
            rd0_en <= r_ok;
            if (r_ok) begin
                rd0_addr <= req[r_idx].addr[ADDR_W-1:0];
                rd_id_q  <= r_idx;
            end
            if (w1_ok)         wr_ptr <= ID_W'(lvt_wrap_inc(int'(w1_idx), NUM_REQ));
            else if (w0_found) wr_ptr <= w0_nxt;
            if (r_ok)          rd_ptr <= ID_W'(lvt_wrap_inc(int'(r_idx), NUM_REQ));
            vp[0] <= rd0_en;
            ip[0] <= rd_id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                vp[k] <= vp[k-1];
                ip[k] <= ip[k-1];
            end
        end
    end

    assign rsp_valid = vp[RD_LAT-1];
    assign rsp_id    = ip[RD_LAT-1];
    assign rsp_data  = rsp_valid ? rd0_data : '0;

`ifdef LVT_ARB_STATS_EN
    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic stall;
    assign stall = (w1_found && !w1_ok) || (r_found && !r_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_wr_cnt    <= '0;
            stat_rd_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            stat_wr_cnt    <= sat_add(stat_wr_cnt, {1'b0, w0_found} + {1'b0, w1_ok});
            stat_rd_cnt    <= sat_add(stat_rd_cnt, {1'b0, r_ok});
            stat_stall_cnt <= sat_add(stat_stall_cnt, {1'b0, stall});
        end
    end
`endif

endmodule
